if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  Consumer of hazard-unit controls (pc_write, if_id_write, if_flush) plus the branch redirect.
//  Owns the PC register, a req/ack fetch port to a variable-latency instruction memory, a 1-entry
//  hold buffer, and the IF/ID pipeline register. Sits between the hazard unit/ID stage and imem.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  PC_STEP    4              byte increment per sequential fetch
//  NOP_INSTR  32'h0000_0000  instruction word inserted on flush/bubble
// PORTS
//  clk_i           in   1   clock, all state on rising edge
//  rst_i           in   1   synchronous reset, active-low
//  pc_write_i      in   1   0 = load-use stall: no new fetch issued, PC held
//  if_id_write_i   in   1   0 = IF/ID register holds its contents
//  if_flush_i      in   1   1 = IF/ID loaded with NOP/invalid at this edge
//  redirect_i      in   1   1-cycle pulse: taken branch/jump, PC <= redirect_pc_i
//  redirect_pc_i   in   32  redirect target
//  imem_req_o      out  1   fetch request (1-cycle pulse)
//  imem_addr_o     out  32  fetch address, valid while imem_req_o=1
//  imem_ack_i      in   1   instruction data valid (>=1 cycle after req)
//  imem_data_i     in   32  instruction word, valid with ack
//  if_id_pc4_o     out  32  fetched PC + PC_STEP
//  if_id_instr_o   out  32  fetched instruction
//  if_id_valid_o   out  1   IF/ID holds a real instruction
//  fetch_busy_o    out  1   1 when state != IDLE
// BEHAVIOUR
//  Reset (rst_i=0 at edge): pc_q=RESET_PC, state=IDLE, drop_q=0, hold buffer empty,
//   if_id_pc4_o=0, if_id_instr_o=NOP_INSTR, if_id_valid_o=0. imem_req_o=0 while rst_i=0.
//   Reset mid-fetch abandons the request; a late ack after reset is ignored (state IDLE).
//  FSM states: IDLE (no fetch outstanding), WAIT (req issued, awaiting ack), HOLD (word buffered).
//  IDLE: imem_req_o = pc_write_i & ~redirect_i; imem_addr_o = pc_q. On issue: req_pc_q<=pc_q,
//   pc_q<=pc_q+PC_STEP (mod 2^32), ->WAIT. No issue -> stay IDLE.
//  WAIT: on ack: if drop_q|redirect_i -> discard word, drop_q<=0, ->IDLE;
//   else if if_id_write_i & ~if_flush_i -> load IF/ID {req_pc_q+PC_STEP, data, 1}, ->IDLE;
//   else -> store word+pc4 in hold buffer, ->HOLD. No ack: redirect_i sets drop_q=1.
//  HOLD: redirect_i -> discard buffer, ->IDLE; else if if_id_write_i & ~if_flush_i -> buffer
//   into IF/ID, ->IDLE; else stay. imem_req_o=0 in WAIT/HOLD (max one fetch outstanding).
//  Redirect: pc_q<=redirect_pc_i at the edge, overriding pc_write_i=0 and any increment.
//  IF/ID priority per edge: reset > if_flush_i (NOP, valid=0, pc4=0) > if_id_write_i=0 (hold)
//   > new word from ack/buffer > bubble (NOP, valid=0).
//  Latency: ack in cycle after req + if_id_write_i=1 -> IF/ID valid at that same edge;
//   back-to-back throughput one instruction per 2 cycles (issue, ack).
//  Simultaneous if_flush_i & ack without redirect: IF/ID flushed, word kept in HOLD.
// TESTING
//  1 reset, ack 1 cycle after each req, all enables 1 -> addrs 0,4,8; IF/ID pc4 4,8,12, valid=1.
//  2 ack latency 3 cycles -> fetch_busy_o=1 for 3 cycles, no second req until ack, pc4=4.
//  3 if_id_write_i=0 during ack of addr 8 -> state HOLD, IF/ID keeps pc4=8; release -> pc4=12.
//  4 redirect_i to 0x100 while WAIT, ack next cycle -> word discarded, next req addr=0x100.
//  5 pc_write_i=0 & redirect_i same cycle in IDLE -> no req, pc_q=0x100, next cycle req 0x100.
//  6 if_flush_i=1 with IF/ID valid -> valid=0, instr=NOP; rst_i=0 in WAIT -> IDLE, late ack ignored.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control: owns the PC, a single-outstanding req/ack port to imem,
// a one-entry hold buffer for words IF/ID cannot take yet, and the IF/ID register.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        if_id_write_i,
    input  logic        if_flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        fetch_busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_drop;
    logic [31:0] r_req_pc;
    logic [31:0] r_buf_pc4;
    logic [31:0] r_buf_instr;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic        w_issue;
    logic        w_accept;
    logic        w_ack_word;
    logic        w_buf_word;
    logic [31:0] w_new_pc4;
    logic [31:0] w_new_instr;

    // A redirect in the same cycle suppresses the fetch: the old PC is already stale.
    assign w_issue     = rst_i & (r_state == S_IDLE) & pc_write_i & ~redirect_i;
    assign w_accept    = if_id_write_i & ~if_flush_i;
    assign w_ack_word  = (r_state == S_WAIT) & imem_ack_i & ~r_drop & ~redirect_i;
    assign w_buf_word  = (r_state == S_HOLD) & ~redirect_i;
    assign w_new_pc4   = w_buf_word ? r_buf_pc4 : (r_req_pc + PC_STEP);
    assign w_new_instr = w_buf_word ? r_buf_instr : imem_data_i;

    assign imem_req_o    = w_issue;
    assign imem_addr_o   = r_pc;
    assign fetch_busy_o  = (r_state != S_IDLE);
    assign if_id_pc4_o   = r_ifid_pc4;
    assign if_id_instr_o = r_ifid_instr;
    assign if_id_valid_o = r_ifid_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_ifid_pc4   <= 32'h0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            if (redirect_i) begin
                r_pc <= redirect_pc_i;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        if (r_drop || redirect_i) begin
                            r_drop  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (w_accept) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else if (redirect_i) begin
                        // Fetch in flight is now wrong-path; swallow its ack when it lands.
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_i || w_accept) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A bubble clears instr/valid but leaves pc4 as it was.
            if (if_flush_i) begin
                r_ifid_pc4   <= 32'h0;
                r_ifid_instr <= NOP_INSTR;
                r_ifid_valid <= 1'b0;
            end else if (if_id_write_i) begin
                if (w_ack_word || w_buf_word) begin
                    r_ifid_pc4   <= w_new_pc4;
                    r_ifid_instr <= w_new_instr;
                    r_ifid_valid <= 1'b1;
                end else begin
                    r_ifid_instr <= NOP_INSTR;
                    r_ifid_valid <= 1'b0;
                end
            end
        end
    end

    // Request address and buffered word are plain data; the FSM qualifies them.
    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_req_pc <= r_pc;
        end
        if ((r_state == S_WAIT) && w_ack_word && !w_accept) begin
            r_buf_pc4   <= w_new_pc4;
            r_buf_instr <= imem_data_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a table of directed vectors, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, pcw, ifw, fl, rd, ack;
    logic [31:0] rpc, data;
    logic        req, valid, busy;
    logic [31:0] addr, pc4, instr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pc_write_i   (pcw),
        .if_id_write_i(ifw),
        .if_flush_i   (fl),
        .redirect_i   (rd),
        .redirect_pc_i(rpc),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_ack_i   (ack),
        .imem_data_i  (data),
        .if_id_pc4_o  (pc4),
        .if_id_instr_o(instr),
        .if_id_valid_o(valid),
        .fetch_busy_o (busy)
    );

    // Reference model: outstanding fetches and buffered words kept as queues.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] w;
    } word_t;

    logic [31:0] m_pc;
    logic [31:0] q_out[$];
    word_t       q_buf[$];
    bit          m_drop;
    logic [31:0] m_pc4, m_instr;
    logic        m_valid;
    bit          m_known = 1'b0;
    logic        seen_req;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic bit m_req();
        return rst && (q_out.size() == 0) && (q_buf.size() == 0) && pcw && !rd;
    endfunction

    function automatic void model_update();
        bit    issue, have, from_buf, taken;
        word_t cand;
        if (!rst) begin
            m_pc = RESET_PC;
            q_out.delete();
            q_buf.delete();
            m_drop  = 1'b0;
            m_pc4   = 32'h0;
            m_instr = NOP_INSTR;
            m_valid = 1'b0;
            m_known = 1'b1;
            return;
        end
        issue = m_req();
        have = 1'b0; from_buf = 1'b0; taken = 1'b0; cand = '0;
        if (q_out.size() > 0) begin
            if (ack) begin
                if (m_drop || rd) m_drop = 1'b0;
                else begin
                    cand.pc4 = q_out[0] + PC_STEP;
                    cand.w   = data;
                    have     = 1'b1;
                end
                void'(q_out.pop_front());
            end else if (rd) begin
                m_drop = 1'b1;
            end
        end else if (q_buf.size() > 0) begin
            if (rd) q_buf.delete();
            else begin
                cand = q_buf[0]; have = 1'b1; from_buf = 1'b1;
            end
        end
        if (fl) begin
            m_pc4 = 32'h0; m_instr = NOP_INSTR; m_valid = 1'b0;
        end else if (ifw) begin
            if (have) begin
                m_pc4 = cand.pc4; m_instr = cand.w; m_valid = 1'b1; taken = 1'b1;
            end else begin
                m_instr = NOP_INSTR; m_valid = 1'b0;
            end
        end
        if (have && taken && from_buf) void'(q_buf.pop_front());
        if (have && !taken && !from_buf) q_buf.push_back(cand);
        if (issue) q_out.push_back(m_pc);
        if (rd) m_pc = rpc;
        else if (issue) m_pc = m_pc + PC_STEP;
    endfunction

    // One clock: compare on the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        seen_req = req;
        if (m_known) begin
            chk("model_req", 32'(req), 32'(m_req()));
            chk("model_busy", 32'(busy), 32'((q_out.size() + q_buf.size()) != 0));
            if (m_req()) chk("model_addr", addr, m_pc);
            chk("model_pc4", pc4, m_pc4);
            chk("model_instr", instr, m_instr);
            chk("model_valid", 32'(valid), 32'(m_valid));
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic w, input logic f, input logic r,
                         input logic [31:0] t, input logic a, input logic [31:0] d);
        pcw = p; ifw = w; fl = f; rd = r; rpc = t; ack = a; data = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        #1;
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_pc4", pc4, 32'h0);
        chk("rst_instr", instr, NOP_INSTR);
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        pcw, ifw, ack;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_busy, e_valid;
        logic [31:0] e_pc4, e_instr;
    } vec_t;

    vec_t tbl[7];
    int   cnt;

    initial begin
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        rst = 1'b0;

        tbl[0] = '{1, 1, 0, 32'h0,         1, 32'd0,  0, 0, 32'd0,  NOP_INSTR};
        tbl[1] = '{1, 1, 1, 32'h0000_0013, 0, 32'd4,  1, 0, 32'd0,  NOP_INSTR};
        tbl[2] = '{1, 1, 0, 32'h0,         1, 32'd4,  0, 1, 32'd4,  32'h0000_0013};
        tbl[3] = '{1, 1, 1, 32'h0041_0093, 0, 32'd8,  1, 0, 32'd4,  NOP_INSTR};
        tbl[4] = '{1, 1, 0, 32'h0,         1, 32'd8,  0, 1, 32'd8,  32'h0041_0093};
        tbl[5] = '{1, 1, 1, 32'h00A5_0513, 0, 32'd12, 1, 0, 32'd8,  NOP_INSTR};
        tbl[6] = '{1, 1, 0, 32'h0,         1, 32'd12, 0, 1, 32'd12, 32'h00A5_0513};

        // Basic streaming, ack one cycle after each request.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].pcw, tbl[i].ifw, 0, 0, 32'h0, tbl[i].ack, tbl[i].data);
            #1;
            chk($sformatf("tbl%0d_req", i), 32'(req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_pc4", i), pc4, tbl[i].e_pc4);
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
            tick();
        end

        // Three-cycle ack latency.
        do_reset();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        #1; chk("lat_req0", 32'(req), 32'h1); chk("lat_addr0", addr, 32'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            #1; chk("lat_busy", 32'(busy), 32'h1); chk("lat_noreq", 32'(req), 32'h0);
            tick();
        end
        drive(1, 1, 0, 0, 32'h0, 1, 32'hDEAD_0001);
        #1; chk("lat_busy_ack", 32'(busy), 32'h1); chk("lat_noreq_ack", 32'(req), 32'h0);
        tick();
        #1; chk("lat_pc4", pc4, 32'd4); chk("lat_valid", 32'(valid), 32'h1); chk("lat_idle", 32'(busy), 32'h0);

        // IF/ID stalled during the ack of addr 8: word parks in the hold buffer.
        do_reset();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);          tick();
        drive(1, 1, 0, 0, 32'h0, 1, 32'h1111_0000);  tick();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);          tick();
        drive(1, 1, 0, 0, 32'h0, 1, 32'h2222_0000);  tick();
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        #1; chk("hold_addr8", addr, 32'd8);
        tick();
        drive(1, 0, 0, 0, 32'h0, 1, 32'h3333_0000);  tick();
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        #1; chk("hold_busy", 32'(busy), 32'h1); chk("hold_pc4", pc4, 32'd8); chk("hold_noreq", 32'(req), 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);          tick();
        #1; chk("rel_pc4", pc4, 32'd12); chk("rel_instr", instr, 32'h3333_0000); chk("rel_valid", 32'(valid), 32'h1);

        // Redirect while waiting: the late word is discarded.
        do_reset();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);          tick();
        drive(1, 1, 0, 1, 32'h100, 0, 32'h0);        tick();
        drive(1, 1, 0, 0, 32'h0, 1, 32'hBAD0_BAD0);  tick();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        #1; chk("redir_valid", 32'(valid), 32'h0); chk("redir_req", 32'(req), 32'h1); chk("redir_addr", addr, 32'h100);
        tick();

        // Stall and redirect together in IDLE.
        do_reset();
        drive(0, 1, 0, 1, 32'h100, 0, 32'h0);
        #1; chk("stall_redir_noreq", 32'(req), 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        #1; chk("stall_redir_req", 32'(req), 32'h1); chk("stall_redir_addr", addr, 32'h100);
        tick();

        // Flush of a valid IF/ID, then reset mid-fetch with a late ack.
        do_reset();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);          tick();
        drive(0, 1, 0, 0, 32'h0, 1, 32'h5555_AAAA); tick();
        #1; chk("pre_flush_valid", 32'(valid), 32'h1);
        drive(0, 1, 1, 0, 32'h0, 0, 32'h0);          tick();
        #1; chk("flush_valid", 32'(valid), 32'h0); chk("flush_instr", instr, NOP_INSTR); chk("flush_pc4", pc4, 32'h0);
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        #1; chk("mid_req", 32'(req), 32'h1); chk("mid_addr", addr, 32'd4);
        tick();
        rst = 1'b0; drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        #1; chk("mid_rst_req", 32'(req), 32'h0);
        tick();
        rst = 1'b1; drive(0, 1, 0, 0, 32'h0, 1, 32'h7777_7777);
        #1; chk("late_busy", 32'(busy), 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        #1; chk("late_valid", 32'(valid), 32'h0); chk("late_busy2", 32'(busy), 32'h0);
        chk("late_req", 32'(req), 32'h1); chk("late_addr", addr, RESET_PC);
        tick();

        // Randomized traffic against the reference model; imem acks 1..3 cycles after a request.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom_range(0, 79) != 0);
            pcw  = ($urandom_range(0, 9) < 8);
            ifw  = ($urandom_range(0, 9) < 8);
            fl   = ($urandom_range(0, 9) == 0);
            rd   = ($urandom_range(0, 7) == 0);
            rpc  = $urandom & 32'hFFFF_FFFC;
            ack  = (cnt == 1);
            data = $urandom;
            tick();
            if (cnt > 0) cnt--;
            if (seen_req) cnt = $urandom_range(1, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
